// File: rtl/l1_writeback_buffer.sv
// Single-entry L1->L2 writeback buffer: holds one evicted dirty line until L2 acknowledges it.
// Optional probe forwarding from the buffered line is enabled by defining L1_WB_FORWARD_EN.
module l1_writeback_buffer #(
  parameter int LINE_BITS   = 256,
  parameter int ADDR_BITS   = 16,
  parameter int OFFSET_BITS = 5,
  parameter int CNT_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 evict_req,
  input  logic [ADDR_BITS-1:0] evict_addr,
  input  logic [LINE_BITS-1:0] evict_data,
  output logic                 evict_ready,
  input  logic                 l2_grant,
  output logic                 l2_write,
  output logic [ADDR_BITS-1:0] l2_address,
  output logic [LINE_BITS-1:0] l2_wdata,
  input  logic                 l2_resp,
  input  logic [ADDR_BITS-1:0] probe_addr,
  output logic                 probe_hit,
  output logic [LINE_BITS-1:0] probe_data,
  output logic [CNT_BITS-1:0]  wb_count,
  output logic                 drop_err
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e               state_q;
  logic                 l2_write_q;
  logic [ADDR_BITS-1:0] line_addr_q;
  logic [LINE_BITS-1:0] line_data_q;
  logic [CNT_BITS-1:0]  wb_count_q;
  logic                 drop_err_q;
  logic                 unused_bits;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      l2_write_q  <= 1'b0;
      line_addr_q <= '0;
      line_data_q <= '0;
      wb_count_q  <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (evict_req) begin
            line_addr_q <= {evict_addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            line_data_q <= evict_data;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (l2_grant) begin
            state_q    <= ST_WRITE;
            l2_write_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          // Grant is no longer consulted; the request is held until L2 answers.
          if (l2_resp) begin
            state_q    <= ST_EMPTY;
            l2_write_q <= 1'b0;
            if (wb_count_q != {CNT_BITS{1'b1}}) begin
              wb_count_q <= wb_count_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          l2_write_q <= 1'b0;
        end
      endcase
      // Any eviction offered while the buffer is occupied is lost, including on the resp cycle.
      if (evict_req && (state_q != ST_EMPTY)) begin
        drop_err_q <= 1'b1;
      end
    end
  end

  assign evict_ready = (state_q == ST_EMPTY);
  assign l2_write    = l2_write_q;
  assign l2_address  = line_addr_q;
  assign l2_wdata    = line_data_q;
  assign wb_count    = wb_count_q;
  assign drop_err    = drop_err_q;

`ifdef L1_WB_FORWARD_EN
  assign probe_hit   = (state_q != ST_EMPTY) &&
                       (probe_addr[ADDR_BITS-1:OFFSET_BITS] == line_addr_q[ADDR_BITS-1:OFFSET_BITS]);
  assign probe_data  = probe_hit ? line_data_q : '0;
  assign unused_bits = ^{evict_addr[OFFSET_BITS-1:0], probe_addr[OFFSET_BITS-1:0]};
`else
  assign probe_hit   = 1'b0;
  assign probe_data  = '0;
  assign unused_bits = ^{evict_addr[OFFSET_BITS-1:0], probe_addr};
`endif

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// Directed bench for l1_writeback_buffer: cycle table plus reset and saturation sequences.
// Probe expectations follow whether L1_WB_FORWARD_EN is defined for the build.
module tb_l1_writeback_buffer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         evict_req = 1'b0;
  logic [15:0]  evict_addr = '0;
  logic [255:0] evict_data = '0;
  logic         evict_ready;
  logic         l2_grant = 1'b0;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [255:0] l2_wdata;
  logic         l2_resp = 1'b0;
  logic [15:0]  probe_addr = '0;
  logic         probe_hit;
  logic [255:0] probe_data;
  logic [7:0]   wb_count;
  logic         drop_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l1_writeback_buffer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .evict_req  (evict_req),
    .evict_addr (evict_addr),
    .evict_data (evict_data),
    .evict_ready(evict_ready),
    .l2_grant   (l2_grant),
    .l2_write   (l2_write),
    .l2_address (l2_address),
    .l2_wdata   (l2_wdata),
    .l2_resp    (l2_resp),
    .probe_addr (probe_addr),
    .probe_hit  (probe_hit),
    .probe_data (probe_data),
    .wb_count   (wb_count),
    .drop_err   (drop_err)
  );

  typedef struct {
    string        name;
    logic         ev;
    logic [15:0]  ea;
    logic [255:0] ed;
    logic         g;
    logic         r;
    logic [15:0]  pa;
    logic         x_rdy;
    logic         x_wr;
    logic [15:0]  x_addr;
    logic [255:0] x_data;
    logic         x_hit;
    logic [7:0]   x_cnt;
    logic         x_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [255:0] mk_line(input logic [15:0] base);
    logic [255:0] l;
    for (int i = 0; i < 16; i++) l[16*i +: 16] = base + 16'(i);
    return l;
  endfunction

  function automatic logic fwd(input logic h);
`ifdef L1_WB_FORWARD_EN
    return h;
`else
    return 1'b0 & h;
`endif
  endfunction

  task automatic add(input string nm, input logic ev, input logic [15:0] ea, input logic [255:0] ed,
                     input logic g, input logic r, input logic [15:0] pa,
                     input logic x_rdy, input logic x_wr, input logic [15:0] x_addr,
                     input logic [255:0] x_data, input logic x_hit, input logic [7:0] x_cnt,
                     input logic x_drop);
    vec_t v;
    v.name = nm; v.ev = ev; v.ea = ea; v.ed = ed; v.g = g; v.r = r; v.pa = pa;
    v.x_rdy = x_rdy; v.x_wr = x_wr; v.x_addr = x_addr; v.x_data = x_data;
    v.x_hit = fwd(x_hit); v.x_cnt = x_cnt; v.x_drop = x_drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string nm, input logic rdy, input logic wr, input logic [15:0] addr,
                          input logic [255:0] data, input logic hit, input logic [7:0] cnt,
                          input logic drop);
    chk({nm, ".ready"}, 256'(evict_ready), 256'(rdy));
    chk({nm, ".write"}, 256'(l2_write), 256'(wr));
    chk({nm, ".addr"}, 256'(l2_address), 256'(addr));
    chk({nm, ".wdata"}, l2_wdata, data);
    chk({nm, ".hit"}, 256'(probe_hit), 256'(hit));
    chk({nm, ".pdata"}, probe_data, hit ? data : 256'd0);
    chk({nm, ".count"}, 256'(wb_count), 256'(cnt));
    chk({nm, ".drop"}, 256'(drop_err), 256'(drop));
  endtask

  task automatic drive(input logic ev, input logic [15:0] ea, input logic [255:0] ed,
                       input logic g, input logic r);
    evict_req = ev; evict_addr = ea; evict_data = ed; l2_grant = g; l2_resp = r;
  endtask

  logic [255:0] d1, d2, d3, z;

  initial begin
    d1 = mk_line(16'hA000);
    d2 = mk_line(16'hB000);
    d3 = mk_line(16'hC000);
    z  = '0;

    // name, ev, ea, ed, g, r, pa | rdy, wr, addr, data, hit, cnt, drop
    add("t1_evict", 1, 16'h1234, d1, 1, 0, 16'h123E, 0, 0, 16'h1220, d1, 1, 8'd0, 0);
    add("t1_grant", 0, 16'h0000, z,  1, 0, 16'h123E, 0, 1, 16'h1220, d1, 1, 8'd0, 0);
    add("t1_wait1", 0, 16'h0000, z,  0, 0, 16'h1240, 0, 1, 16'h1220, d1, 0, 8'd0, 0);
    add("t1_wait2", 0, 16'h0000, z,  0, 0, 16'h123E, 0, 1, 16'h1220, d1, 1, 8'd0, 0);
    add("t1_resp",  0, 16'h0000, z,  0, 1, 16'h123E, 1, 0, 16'h1220, d1, 0, 8'd1, 0);
    add("spur_rsp", 0, 16'h0000, z,  0, 1, 16'h123E, 1, 0, 16'h1220, d1, 0, 8'd1, 0);
    add("t2_evict", 1, 16'h5678, d2, 0, 0, 16'h5660, 0, 0, 16'h5660, d2, 1, 8'd1, 0);
    for (int i = 0; i < 10; i++)
      add("t2_hold", 0, 16'h0000, z, 0, 0, 16'h5660, 0, 0, 16'h5660, d2, 1, 8'd1, 0);
    add("t2_grant", 0, 16'h0000, z,  1, 0, 16'h5660, 0, 1, 16'h5660, d2, 1, 8'd1, 0);
    add("t2_write", 0, 16'h0000, z,  0, 0, 16'h5660, 0, 1, 16'h5660, d2, 1, 8'd1, 0);
    add("t2_resp",  0, 16'h0000, z,  0, 1, 16'h5660, 1, 0, 16'h5660, d2, 0, 8'd2, 0);
    add("t3_evict", 1, 16'h1234, d1, 1, 0, 16'h0000, 0, 0, 16'h1220, d1, 0, 8'd2, 0);
    add("t3_grant", 0, 16'h0000, z,  1, 0, 16'h1220, 0, 1, 16'h1220, d1, 1, 8'd2, 0);
    add("t3_drop",  1, 16'h4000, d3, 0, 0, 16'h4000, 0, 1, 16'h1220, d1, 0, 8'd2, 1);
    add("t3_droprsp", 1, 16'h4000, d3, 0, 1, 16'h123E, 1, 0, 16'h1220, d1, 0, 8'd3, 1);
    add("t3_ready", 0, 16'h0000, z,  0, 0, 16'h123E, 1, 0, 16'h1220, d1, 0, 8'd3, 1);

    // reset state
    reset_n = 1'b0;
    probe_addr = 16'h0000;
    #12;
    chk_outs("reset", 1, 0, 16'h0000, z, 0, 8'd0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].ev, vecs[k].ea, vecs[k].ed, vecs[k].g, vecs[k].r);
      probe_addr = vecs[k].pa;
      @(posedge clk);
      #1;
      chk_outs(vecs[k].name, vecs[k].x_rdy, vecs[k].x_wr, vecs[k].x_addr, vecs[k].x_data,
               vecs[k].x_hit, vecs[k].x_cnt, vecs[k].x_drop);
    end

    // reset asserted mid-WRITE
    @(negedge clk);
    drive(1, 16'h2000, d2, 0, 0);
    probe_addr = 16'h2000;
    @(negedge clk);
    drive(0, 16'h0000, z, 1, 0);
    @(posedge clk);
    #1;
    chk("rst_pre.write", 256'(l2_write), 256'd1);
    #2;
    drive(0, 16'h0000, z, 0, 0);
    reset_n = 1'b0;
    #1;
    chk_outs("rst_async", 1, 0, 16'h0000, z, 0, 8'd0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("rst_post", 1, 0, 16'h0000, z, 0, 8'd0, 0);

    // saturating writeback counter
    for (int n = 1; n <= 260; n++) begin
      @(negedge clk);
      drive(1, 16'(n << 5), d3, 1, 0);
      @(negedge clk);
      drive(0, 16'h0000, z, 1, 0);
      @(negedge clk);
      drive(0, 16'h0000, z, 0, 1);
      @(posedge clk);
      #1;
      if (n == 254) chk("sat_254", 256'(wb_count), 256'hFE);
      if (n == 255) chk("sat_255", 256'(wb_count), 256'hFF);
    end
    @(negedge clk);
    drive(0, 16'h0000, z, 0, 0);
    @(posedge clk);
    #1;
    chk("sat_260", 256'(wb_count), 256'hFF);
    chk("sat_ready", 256'(evict_ready), 256'd1);
    @(negedge clk);
    drive(0, 16'h0000, z, 0, 1);
    @(posedge clk);
    #1;
    chk("sat_spur.count", 256'(wb_count), 256'hFF);
    chk("sat_spur.ready", 256'(evict_ready), 256'd1);
    chk("sat_spur.write", 256'(l2_write), 256'd0);
    @(negedge clk);
    drive(0, 16'h0000, z, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_writeback_buffer.md
Name: l1_writeback_buffer

Overview:
Single-entry writeback buffer between the L1 data array and L2. It is the write-direction counterpart of the L1 fill/merge path:
- Captures a dirty 256-bit cacheline evicted by the L1 controller.
- Frees L1 immediately, then transmits the line to L2 under an arbiter grant with a request/response handshake.
- Optionally answers L1 read probes from the buffered line so a refetch never reads stale L2 data.

Parameters:
LINE_BITS, 256, cacheline width (16 words x 16 bits)
ADDR_BITS, 16, byte address width
OFFSET_BITS, 5, byte-offset bits within a line (address bits below the line address)
CNT_BITS, 8, width of the completed-writeback counter

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
evict_req  in  1  one-cycle pulse: capture evict_addr/evict_data
evict_addr  in  16  byte address of evicted line; low 5 bits ignored
evict_data  in  256  evicted cacheline contents
evict_ready  out  1  buffer can accept evict_req this cycle
l2_grant  in  1  arbiter permits L2 write this cycle
l2_write  out  1  write request to L2
l2_address  out  16  line-aligned address (low 5 bits zero)
l2_wdata  out  256  line data to L2
l2_resp  in  1  L2 write complete (one-cycle pulse)
probe_addr  in  16  L1 miss address checked against buffer
probe_hit  out  1  buffered line matches probe_addr[15:5]
probe_data  out  256  buffered line when probe_hit, else zero
wb_count  out  8  completed writebacks, saturating
drop_err  out  1  sticky: evict_req arrived while not ready

Behaviour:
- Reset (async assert, sync release) forces:
  - state=EMPTY, l2_write=0, l2_address=0, l2_wdata=0, probe_hit=0, wb_count=0, drop_err=0, evict_ready=1.
  - Reset mid-WRITE drops l2_write immediately and discards the line.
- States:
  - EMPTY: evict_ready=1. evict_req latches {evict_addr[15:5],5'b0} and evict_data; go to HOLD next edge.
  - HOLD: evict_ready=0, l2_write=0. l2_grant=1 -> go to WRITE next edge.
  - WRITE: l2_write=1, address/data held stable. l2_resp=1 -> EMPTY next edge and wb_count increments (saturates at 255). l2_grant is ignored once in WRITE; the request holds until resp.
- Latency:
  - Earliest l2_write is 2 cycles after evict_req (grant high in HOLD).
  - evict_ready returns the cycle after l2_resp.
- l2_resp outside WRITE is ignored (no state or count change).
- evict_req when evict_ready=0:
  - The request is ignored; the buffer contents are unchanged.
  - drop_err is set and stays set until reset.
- evict_req coincident with l2_resp in WRITE: the request is dropped (ready is still 0) and drop_err is set. The L1 controller must wait for evict_ready.
- l2_address and l2_wdata are registered outputs. They hold the last line after return to EMPTY; they are don't-care there since l2_write=0.
- Probe (when the feature is compiled in) is purely combinational:
  - probe_hit = (state!=EMPTY) && probe_addr[15:5]==buffered line address[15:5].
  - probe_data = buffered line when hit, else 0.

Optional Feature:
Macro L1_WB_FORWARD_EN.
- Defined: probe logic as above; a probe hit is valid in HOLD and WRITE, including the l2_resp cycle.
- Undefined: probe_hit tied 0 and probe_data tied 0. The L1 controller must stall misses while evict_ready=0.

Test Plan:
1. Reset then evict_req with addr=16'h1234, data pattern word i = 16'hA000+i; grant high -> l2_write rises 2 cycles later, l2_address=16'h1220, l2_wdata matches; resp after 3 cycles -> evict_ready=1 next cycle, wb_count=1.
2. Grant withheld 10 cycles in HOLD -> l2_write stays 0, evict_ready=0 throughout; grant pulse -> l2_write=1 until resp.
3. Second evict_req (addr 16'h4000) while in WRITE and on the resp cycle -> drop_err=1, l2_address stays 16'h1220, data unchanged.
4. With L1_WB_FORWARD_EN:
   - probe 16'h123E while buffered -> probe_hit=1, probe_data=line.
   - probe 16'h1240 -> hit=0, data=0.
   - After return to EMPTY -> hit=0.
5. Assert reset_n=0 mid-WRITE -> l2_write falls same cycle asynchronously; after release state=EMPTY, wb_count=0, drop_err=0.
6. 260 back-to-back complete writebacks -> wb_count saturates at 8'hFF; spurious l2_resp in EMPTY leaves count and state unchanged.
